inst_fetch_ctrl: RTL and testbench

- Sequencing controller for the 4096 x 19-bit instruction memory.
- Owns the program counter and drives the memory address port.
- Captures the combinational read data into a small prefetch buffer.
- Presents {instruction, pc} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) from execute, and halts from the hazard/control unit.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 78 +++++++
 rtl/inst_fetch_ctrl.sv | 92 +++++++++
 tb/tb_inst_fetch_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   ADDR_W        : instruction address width (memory depth 2**ADDR_W)
//   INST_W        : instruction word width
//   RESET_PC      : default pc loaded on reset
//   fetch_entry_t : one prefetch buffer entry, {instruction, address}
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wr_data_i at the tail (caller guarantees space)
//   pop_i      : drop the head entry (caller guarantees non-empty)
//   flush_i    : discard all entries; overrides push_i and pop_i
//   wr_data_i  : entry to write on push
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : number of valid entries
//   head_o     : head entry, forced to zero while empty
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wr_data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the pc, addresses the instruction
// memory, captures its combinational read data into a prefetch buffer and
// presents {instruction, pc} to decode over valid/ready.
// ADDR_W/INST_W must match fetch_pkg, which sizes the buffer entries.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : memory address, always equal to pc
//   imem_data       : memory read data for imem_addr
//   redirect_valid  : one-cycle pulse, flush and restart at redirect_pc
//   redirect_pc     : redirect target
//   halt            : level, freezes pc and fetch while high
//   inst_valid      : head entry valid
//   inst_ready      : decode accepts the head this cycle
//   inst_data       : head instruction
//   inst_pc         : head instruction address
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INST_W   = fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pop, space, push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      wr_entry, head;

    assign pop   = !fifo_empty && inst_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still stream.
    assign space = !fifo_full || pop;
    assign push  = !redirect_valid && !halt && space;
    // A redirect squashes the head even if decode is taking it.
    assign fifo_pop = pop && !redirect_valid;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign wr_entry.inst = imem_data;
    assign wr_entry.pc   = pc_q;

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (fifo_pop),
        .flush_i   (redirect_valid),
        .wr_data_i (wr_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .head_o    (head)
    );

    assign imem_addr  = pc_q;
    assign inst_valid = (fifo_count != '0);
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    always #5 clk = ~clk;

    // Memory image: word k holds k + 100.
    assign imem_data = {{(INST_W-ADDR_W){1'b0}}, imem_addr} + 19'd100;

    inst_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .RESET_PC (12'd0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        bit          rstb;   // apply reset before this cycle
        bit          rdy;
        bit          hlt;
        bit          rv;
        logic [11:0] rpc;
        bit          ev;     // expected inst_valid
        logic [11:0] eaddr;  // expected imem_addr
        logic [11:0] epc;    // expected head pc when ev
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit rstb, input bit rdy, input bit hlt, input bit rv,
                                input logic [11:0] rpc, input bit ev,
                                input logic [11:0] eaddr, input logic [11:0] epc);
        vec_t v;
        v.rstb = rstb; v.rdy = rdy; v.hlt = hlt; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.eaddr = eaddr; v.epc = epc;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inst_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sb_pop();
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_delivery", inst_pc, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("sb_pc", inst_pc, e);
            chk("sb_data", inst_data, e + 100);
        end
    endtask

    initial begin
        //  rstb rdy hlt rv  rpc        ev eaddr      epc
        // streaming after reset
        add(1, 1, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'h001, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'h002, 12'h001);
        add(0, 1, 0, 0, 12'h000, 1, 12'h003, 12'h002);
        add(0, 1, 0, 0, 12'h000, 1, 12'h004, 12'h003);
        // backpressure: ready low for 5 cycles after first valid
        add(1, 0, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        add(0, 0, 0, 0, 12'h000, 1, 12'h001, 12'h000);
        add(0, 0, 0, 0, 12'h000, 1, 12'h002, 12'h000);
        add(0, 0, 0, 0, 12'h000, 1, 12'h002, 12'h000);
        add(0, 0, 0, 0, 12'h000, 1, 12'h002, 12'h000);
        add(0, 0, 0, 0, 12'h000, 1, 12'h002, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'h002, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'h003, 12'h001);
        add(0, 1, 0, 0, 12'h000, 1, 12'h004, 12'h002);
        // redirect with full buffer and ready high: head squashed
        add(0, 1, 0, 1, 12'h200, 1, 12'h005, 12'h003);
        add(0, 1, 0, 0, 12'h000, 0, 12'h200, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'h201, 12'h200);
        // halt for 3 cycles: drain, then freeze, then resume
        add(0, 1, 1, 0, 12'h000, 1, 12'h202, 12'h201);
        add(0, 1, 1, 0, 12'h000, 0, 12'h202, 12'h000);
        add(0, 1, 1, 0, 12'h000, 0, 12'h202, 12'h000);
        add(0, 1, 0, 0, 12'h000, 0, 12'h202, 12'h000);
        // back-to-back redirects, the second under halt; then wrap-around
        add(0, 1, 0, 1, 12'h300, 1, 12'h203, 12'h202);
        add(0, 1, 1, 1, 12'hFFE, 0, 12'h300, 12'h000);
        add(0, 1, 0, 0, 12'h000, 0, 12'hFFE, 12'h000);
        add(0, 1, 0, 0, 12'h000, 1, 12'hFFF, 12'hFFE);
        add(0, 1, 0, 0, 12'h000, 1, 12'h000, 12'hFFF);
        add(0, 1, 0, 0, 12'h000, 1, 12'h001, 12'h000);
        // fill the buffer ahead of the asynchronous reset
        add(0, 0, 0, 0, 12'h000, 1, 12'h002, 12'h001);
        add(0, 0, 0, 0, 12'h000, 1, 12'h003, 12'h001);

        // Delivery order decode must see.
        exp_q = '{12'h000, 12'h001, 12'h002, 12'h003,
                  12'h000, 12'h001, 12'h002,
                  12'h200, 12'h201,
                  12'hFFE, 12'hFFF, 12'h000};

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rstb) do_reset();
            else @(negedge clk);
            inst_ready     = tbl[i].rdy;
            halt           = tbl[i].hlt;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d_valid", i), inst_valid, tbl[i].ev);
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_head_pc", i), inst_pc, tbl[i].epc);
                chk($sformatf("row%0d_head_data", i), inst_data, tbl[i].epc + 100);
            end
            if (inst_valid && inst_ready && !redirect_valid) sb_pop();
        end

        // Asynchronous reset between edges with two entries buffered.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", inst_valid, 0);
        chk("async_rst_addr", imem_addr, 0);
        chk("async_rst_inst_pc", inst_pc, 0);
        @(posedge clk);
        @(negedge clk);
        inst_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
        rst_n = 1'b1;
        exp_q.push_back(12'h000);
        #1;
        chk("post_rst_valid", inst_valid, 0);
        chk("post_rst_addr", imem_addr, 0);
        @(negedge clk);
        #1;
        chk("post_rst_valid1", inst_valid, 1);
        chk("post_rst_addr1", imem_addr, 1);
        if (inst_valid && inst_ready) sb_pop();
        else chk("post_rst_delivery", inst_valid, 1);

        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
